inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Hardware boot loader sitting directly upstream of inst_rom and in front of riscv_cpu's reset/go/start_pc inputs.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into inst_rom at consecutive byte addresses (0, 4, 8, ...).
- Appends a zero terminator word, holds the CPU in reset for a programmable count, then releases it with go asserted.
- Monitors halt and reports completion. Replaces file-driven ROM preloading so the SoC can boot from a host link.

Parameters:
DEPTH, 32, ROM capacity in words including terminator slot; power of two, >=2
START_PC, 0, value driven on cpu_start_pc
RESET_HOLD, 2, cycles cpu_reset stays high after go is raised; >=1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
in_valid  input  1  host word valid
in_ready  output  1  loader can accept a word
in_data  input  32  instruction word
in_last  input  1  marks final word of program
rom_write_enable  output  1  write strobe to inst_rom
rom_addr  output  32  byte address to inst_rom (word index * 4)
rom_data  output  32  word to write
cpu_reset  output  1  reset to riscv_cpu
cpu_go  output  1  go to riscv_cpu
cpu_start_pc  output  32  start_pc to riscv_cpu
cpu_halt  input  1  halt from riscv_cpu
busy  output  1  high from reset until DONE or ERR
done  output  1  CPU halted after a successful run
error  output  1  load aborted; CPU never released

Behaviour:
- Reset values:
  - FSM state LOAD; word pointer ptr = 0.
  - rom_write_enable = 0, rom_addr = 0, rom_data = 0.
  - cpu_reset = 1, cpu_go = 0, cpu_start_pc = START_PC.
  - busy = 1, done = 0, error = 0.
- Reset is asynchronous at any time, including mid-load or mid-run. All state returns to reset values; ROM contents are not cleared.
- States are LOAD, TERM, HOLD, RUN, DONE, ERR. in_ready = (state == LOAD), combinational from the state register.
- LOAD:
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - Next cycle: rom_write_enable = 1, rom_addr = ptr*4, rom_data = in_data; ptr increments. Write latency is 1 cycle; outputs are registered.
  - rom_write_enable is 0 in any cycle not following a transfer.
  - Transfer with in_last = 1 -> TERM.
  - Program capacity is DEPTH-1 words. A transfer at ptr == DEPTH-2 with in_last = 0 -> ERR. That word is still written.
  - in_valid without ready is ignored; no data is lost because ready gates acceptance.
- TERM: one cycle. rom_write_enable = 1, rom_addr = ptr*4, rom_data = 0. Then -> HOLD with hold counter = RESET_HOLD.
- HOLD:
  - cpu_go = 1 and cpu_reset = 1. Counter decrements each cycle.
  - At 0 -> RUN. cpu_reset deasserts exactly RESET_HOLD cycles after cpu_go rises.
- RUN: cpu_reset = 0, cpu_go = 1. cpu_halt = 1 -> DONE. cpu_halt is ignored in all other states.
- DONE: cpu_go = 0, cpu_reset = 0, done = 1, busy = 0. Sticky until reset.
- ERR: in_ready = 0, cpu_reset = 1, cpu_go = 0, error = 1, busy = 0. Sticky until reset.
- ptr width is clog2(DEPTH). rom_addr is zero-extended and never wraps because ERR blocks the overflow.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - The in_last word is a checksum and is not written to ROM.
  - The loader keeps a 32-bit sum, modulo 2^32, of all preceding accepted words; it resets to 0.
  - Sum equal to the checksum -> TERM, with the terminator written at the current ptr.
  - Mismatch -> ERR.
  - in_last as the first word is valid if its value is 0: empty program, terminator at address 0.
  - The capacity check applies to program words only.
- When undefined: the in_last word is an ordinary program word and error is driven only by overflow.

Test Plan:
1. Stream 0x00500093, 0x00100113, 0x002081B3 (last) with in_valid held high -> ROM writes at 0, 4, 8 on consecutive cycles; 0x00000000 written at 12; cpu_go rises next cycle; cpu_reset falls 2 cycles later; cpu_start_pc = 0.
2. Case 1 with in_valid toggling 1/0 each cycle -> writes occur only after accepted words; addresses are still contiguous 0, 4, 8, then 12 = 0.
3. Stream 31 words without in_last (DEPTH = 32) -> 31st word written at addr 120; error = 1; in_ready = 0; cpu_reset stays 1; cpu_go stays 0.
4. After case 1, pulse cpu_halt for one cycle in RUN -> done = 1, cpu_go = 0, busy = 0; a further halt or in_valid has no effect.
5. Assert reset during HOLD, then stream 1 word (last) -> all outputs return to reset values immediately; reload writes addr 0 and terminator at addr 4; normal release follows.
6. (LOADER_CHECKSUM_EN) Stream 0x1, 0x2, checksum 0x3 (last) -> writes at 0 and 4, terminator at 8, release. Repeat with checksum 0x4 -> error = 1 and no release.

Source files
------------

// File: rtl/inst_loader.sv
// Boot loader: streams host words into inst_rom, appends a zero terminator, then releases riscv_cpu.
// Optional LOADER_CHECKSUM_EN: the in_last word is a checksum over the program instead of program data.
module inst_loader #(
  parameter int unsigned DEPTH      = 32,
  parameter logic [31:0] START_PC   = 32'h0,
  parameter int unsigned RESET_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        rom_write_enable,
  output logic [31:0] rom_addr,
  output logic [31:0] rom_data,
  output logic        cpu_reset,
  output logic        cpu_go,
  output logic [31:0] cpu_start_pc,
  input  logic        cpu_halt,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned HW = $clog2(RESET_HOLD + 1);

  typedef enum logic [2:0] {
    S_LOAD, S_TERM, S_HOLD, S_RUN, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   ptr_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   sum_q, sum_d;
`endif

  assign ptr_addr = 32'(ptr_q) << 2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
          if (in_last) begin
            state_d = (sum_q == in_data) ? S_TERM : S_ERR;
          end else begin
            we_d   = 1'b1;
            addr_d = ptr_addr;
            data_d = in_data;
            ptr_d  = ptr_q + 1'b1;
            sum_d  = sum_q + in_data;
            // The checksum needs no slot, so the last program slot is DEPTH-2 and DEPTH-1 stays free for the terminator.
            if (ptr_q == PW'(DEPTH - 1)) state_d = S_ERR;
          end
`else
          we_d   = 1'b1;
          addr_d = ptr_addr;
          data_d = in_data;
          ptr_d  = ptr_q + 1'b1;
          if (in_last)                      state_d = S_TERM;
          else if (ptr_q == PW'(DEPTH - 2)) state_d = S_ERR;
`endif
        end
      end
      S_TERM: begin
        we_d    = 1'b1;
        addr_d  = ptr_addr;
        data_d  = '0;
        hold_d  = HW'(RESET_HOLD);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        hold_d = hold_q - 1'b1;
        if (hold_d == '0) state_d = S_RUN;
      end
      S_RUN: begin
        if (cpu_halt) state_d = S_DONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    cpu_reset = 1'b1;
    cpu_go    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      S_HOLD: cpu_go = 1'b1;
      S_RUN: begin
        cpu_reset = 1'b0;
        cpu_go    = 1'b1;
      end
      S_DONE: begin
        cpu_reset = 1'b0;
        busy      = 1'b0;
        done      = 1'b1;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: ;
    endcase
  end

  assign rom_write_enable = we_q;
  assign rom_addr         = addr_q;
  assign rom_data         = data_q;
  assign cpu_start_pc     = START_PC;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: random host streams checked against a stream-level reference model.
`timescale 1ns/1ps
module tb_inst_loader;

  localparam int unsigned DEPTH      = 32;
  localparam int unsigned RESET_HOLD = 2;
  localparam logic [31:0] START_PC   = 32'h0;
`ifdef LOADER_CHECKSUM_EN
  localparam int unsigned OVF_N    = DEPTH;
  localparam int unsigned TERM_GAP = 2;
`else
  localparam int unsigned OVF_N    = DEPTH - 1;
  localparam int unsigned TERM_GAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        rom_write_enable;
  logic [31:0] rom_addr, rom_data;
  logic        cpu_reset, cpu_go;
  logic [31:0] cpu_start_pc;
  logic        cpu_halt = 1'b0;
  logic        busy, done, error;

  always #5 clk = ~clk;

  inst_loader #(.DEPTH(DEPTH), .START_PC(START_PC), .RESET_HOLD(RESET_HOLD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .rom_write_enable(rom_write_enable),
    .rom_addr(rom_addr), .rom_data(rom_data), .cpu_reset(cpu_reset), .cpu_go(cpu_go),
    .cpu_start_pc(cpu_start_pc), .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error)
  );

  typedef logic [31:0] word_q_t[$];
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;

  wr_t         wlog[$];
  logic [63:0] exp_q[$];
  bit          exp_err;
  int          cyc = 0, go_cyc = -1, rel_cyc = -1;
  int          n_chk = 0, n_pass = 0;

  always @(negedge clk) begin
    cyc++;
    if (rom_write_enable) wlog.push_back('{rom_addr, rom_data, cyc});
    if (cpu_go && go_cyc < 0) go_cyc = cyc;
    if (cpu_go && !cpu_reset && rel_cyc < 0) rel_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_log();
    wlog.delete();
    go_cyc  = -1;
    rel_cyc = -1;
  endtask

  // Expected ROM writes and outcome for a host stream, straight from the loader rules.
  function automatic void model(input word_q_t s, input bit has_last);
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum = '0;
`endif
    exp_q.delete();
    exp_err = 1'b0;
    for (int unsigned i = 0; i < s.size(); i++) begin
      bit last = has_last && (i == s.size() - 1);
`ifdef LOADER_CHECKSUM_EN
      if (last) begin
        if (sum == s[i]) exp_q.push_back({32'(i * 4), 32'h0});
        else exp_err = 1'b1;
        return;
      end
      exp_q.push_back({32'(i * 4), s[i]});
      sum += s[i];
      if (i == DEPTH - 1) begin exp_err = 1'b1; return; end
`else
      exp_q.push_back({32'(i * 4), s[i]});
      if (last) begin exp_q.push_back({32'((i + 1) * 4), 32'h0}); return; end
      if (i == DEPTH - 2) begin exp_err = 1'b1; return; end
`endif
    end
  endfunction

  function automatic word_q_t with_last(input word_q_t p);
    word_q_t s = p;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum = '0;
    foreach (p[i]) sum += p[i];
    s.push_back(sum);
`endif
    return s;
  endfunction

  function automatic word_q_t rand_prog(input int unsigned n);
    word_q_t p;
    for (int unsigned i = 0; i < n; i++) p.push_back($urandom);
    return p;
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    cpu_halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_ready"}, 32'(in_ready), 32'd1);
    check({nm, "_we"},    32'(rom_write_enable), 32'd0);
    check({nm, "_addr"},  rom_addr, 32'h0);
    check({nm, "_data"},  rom_data, 32'h0);
    check({nm, "_creset"},32'(cpu_reset), 32'd1);
    check({nm, "_go"},    32'(cpu_go), 32'd0);
    check({nm, "_pc"},    cpu_start_pc, START_PC);
    check({nm, "_busy"},  32'(busy), 32'd1);
    check({nm, "_done"},  32'(done), 32'd0);
    check({nm, "_err"},   32'(error), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge just after the word's accepting edge.
  task automatic send_word(input logic [31:0] w, input logic last, input int unsigned gap);
    for (int unsigned g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    for (int n = 0; n < 64 && !in_ready; n++) @(negedge clk);
    if (!in_ready) check("ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic verify(input string nm, input int unsigned spacing);
    int unsigned nw, nprog;
    for (int n = 0; n < 64 && !(error || (cpu_go && !cpu_reset)); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({nm, "_nwr"}, 32'(wlog.size()), 32'(exp_q.size()));
    nw = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
    for (int unsigned i = 0; i < nw; i++) begin
      check({nm, "_waddr"}, wlog[i].addr, exp_q[i][63:32]);
      check({nm, "_wdata"}, wlog[i].data, exp_q[i][31:0]);
    end
    check({nm, "_error"}, 32'(error), 32'(exp_err));
    if (!exp_err && wlog.size() > 0) begin
      check({nm, "_go_at_term"}, 32'(go_cyc), 32'(wlog[$].cyc));
      check({nm, "_rel_delay"},  32'(rel_cyc - go_cyc), 32'(RESET_HOLD));
      check({nm, "_run_creset"}, 32'(cpu_reset), 32'd0);
      check({nm, "_run_go"},     32'(cpu_go), 32'd1);
      check({nm, "_run_busy"},   32'(busy), 32'd1);
      check({nm, "_run_pc"},     cpu_start_pc, START_PC);
    end else if (exp_err) begin
      check({nm, "_err_ready"},  32'(in_ready), 32'd0);
      check({nm, "_err_creset"}, 32'(cpu_reset), 32'd1);
      check({nm, "_err_go"},     32'(cpu_go), 32'd0);
      check({nm, "_err_busy"},   32'(busy), 32'd0);
      check({nm, "_never_go"},   32'(go_cyc), 32'hffff_ffff);
    end
    if (spacing != 0 && wlog.size() > 1) begin
      nprog = exp_err ? wlog.size() : wlog.size() - 1;
      for (int unsigned i = 1; i < nprog; i++)
        check({nm, "_wr_cycle"}, 32'(wlog[i].cyc - wlog[0].cyc), 32'(i * spacing));
      if (!exp_err && spacing == 1)
        check({nm, "_term_cycle"}, 32'(wlog[$].cyc - wlog[$-1].cyc), 32'(TERM_GAP));
    end
  endtask

  // gapmode: 0 = valid held high, 1 = valid toggling, 2 = random idle gaps.
  task automatic load(input string nm, input word_q_t s, input bit has_last,
                      input int unsigned gapmode, input int unsigned spacing);
    int unsigned gap;
    model(s, has_last);
    foreach (s[i]) begin
      gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : $urandom_range(0, 2);
      send_word(s[i], has_last && (i == s.size() - 1), gap);
    end
    verify(nm, spacing);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    word_q_t p;
    int      nlog;

    do_reset();
    check_reset("reset");

    // Three-word program streamed back to back, then a one-cycle halt.
    p = '{32'h00500093, 32'h00100113, 32'h002081B3};
    load("basic", with_last(p), 1'b1, 0, 1);
    cpu_halt = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    check("halt_done",   32'(done), 32'd1);
    check("halt_go",     32'(cpu_go), 32'd0);
    check("halt_busy",   32'(busy), 32'd0);
    check("halt_creset", 32'(cpu_reset), 32'd0);
    nlog     = wlog.size();
    cpu_halt = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    repeat (3) @(negedge clk);
    cpu_halt = 1'b0;
    in_valid = 1'b0;
    check("done_sticky", 32'(done), 32'd1);
    check("done_ready",  32'(in_ready), 32'd0);
    check("done_nowr",   32'(wlog.size()), 32'(nlog));

    do_reset();
    load("toggle", with_last(p), 1'b1, 1, 2);

    do_reset();
    load("overflow", rand_prog(OVF_N), 1'b0, 0, 1);
    nlog     = wlog.size();
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = $urandom;
    cpu_halt = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    cpu_halt = 1'b0;
    check("ovf_sticky", 32'(error), 32'd1);
    check("ovf_nowr",   32'(wlog.size()), 32'(nlog));
    check("ovf_go",     32'(cpu_go), 32'd0);

    do_reset();
    p = with_last(rand_prog(3));
    foreach (p[i]) send_word(p[i], i == p.size() - 1, 0);
    for (int n = 0; n < 64 && !cpu_go; n++) @(negedge clk);
    check("hold_reached", 32'(cpu_go & cpu_reset), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset("async_rst");
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    load("reload", with_last(rand_prog(1)), 1'b1, 0, 1);

    for (int k = 0; k < 5; k++) begin
      do_reset();
      p = rand_prog((k == 0) ? DEPTH - 1 : $urandom_range(1, 12));
      load("random", with_last(p), 1'b1, 2, 0);
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    load("cks_good", '{32'h1, 32'h2, 32'h3}, 1'b1, 0, 1);
    do_reset();
    load("cks_bad", '{32'h1, 32'h2, 32'h4}, 1'b1, 0, 1);
    do_reset();
    load("cks_empty", '{32'h0}, 1'b1, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
